// File: rtl/id_decoder_if.sv
// ----------------------------------------------------------------------------
// id_decoder_if
// Groups the instruction word and the registered decode results that travel
// between instruction fetch, the decode stage and the execute stage.
//
//   inst      16  instruction word (fetch -> decoder)
//   o_addr_0   3  register read address 0 (rs1 / base)
//   o_addr_1   3  register read address 1 (rs2 / store data)
//   o_w_addr   3  register write address (rd)
//   imm        8  immediate
//   ALU_OP     7  ALU operation code
//   Branch, Mem2Reg, ALUSrc, RF_w_en, DM_w_en, DM_r_en, is_jal : strobes
//
// Modports:
//   master : supplies inst, observes the decode results (fetch side / bench)
//   slave  : consumes inst, produces the decode results (the decoder)
//
// Handshake: there is none. The slave samples inst on every rising clock
// edge and the results are valid for the whole following cycle.
// ----------------------------------------------------------------------------
interface id_decoder_if;
    logic [15:0] inst;
    logic [2:0]  o_addr_0;
    logic [2:0]  o_addr_1;
    logic [2:0]  o_w_addr;
    logic [7:0]  imm;
    logic [6:0]  ALU_OP;
    logic        Branch;
    logic        Mem2Reg;
    logic        ALUSrc;
    logic        RF_w_en;
    logic        DM_w_en;
    logic        DM_r_en;
    logic        is_jal;

    modport master (
        output inst,
        input  o_addr_0, o_addr_1, o_w_addr, imm, ALU_OP,
        input  Branch, Mem2Reg, ALUSrc, RF_w_en, DM_w_en, DM_r_en, is_jal
    );

    modport slave (
        input  inst,
        output o_addr_0, o_addr_1, o_w_addr, imm, ALU_OP,
        output Branch, Mem2Reg, ALUSrc, RF_w_en, DM_w_en, DM_r_en, is_jal
    );
endinterface

// File: rtl/id_decoder.sv
// ----------------------------------------------------------------------------
// id_decoder
// Instruction-decode stage of the 8-bit CPU. Decodes a 16-bit instruction
// into register addresses, an 8-bit immediate, a 7-bit ALU op code and
// datapath strobes. All results are registered once (IF/ID -> EX boundary).
// Any illegal encoding produces an all-zero bubble, identical to the reset
// state.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset, clears every output
//   bus    slave modport of id_decoder_if (inst in, decode results out)
// ----------------------------------------------------------------------------
module id_decoder (
    input  logic         clk,
    input  logic         rst_n,
    id_decoder_if.slave  bus
);

    // Instruction fields
    logic [2:0] op;
    logic [1:0] f2;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [1:0] fn;
    logic [7:0] simm5;

    assign op    = bus.inst[15:13];
    assign f2    = bus.inst[12:11];
    assign rd    = bus.inst[10:8];
    assign ra    = bus.inst[7:5];
    assign rb    = bus.inst[4:2];
    assign fn    = bus.inst[1:0];
    assign simm5 = {{3{bus.inst[4]}}, bus.inst[4:0]};

    localparam logic [2:0] OP_RTYPE  = 3'b000;
    localparam logic [2:0] OP_ALUI   = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_JAL    = 3'b011;
    localparam logic [2:0] OP_MEM    = 3'b100;

    // Next-state (combinational decode) and registered outputs
    logic [2:0] addr_0_d, addr_0_q;
    logic [2:0] addr_1_d, addr_1_q;
    logic [2:0] w_addr_d, w_addr_q;
    logic [7:0] imm_d, imm_q;
    logic [6:0] alu_op_d, alu_op_q;
    logic       branch_d, branch_q;
    logic       mem2reg_d, mem2reg_q;
    logic       alu_src_d, alu_src_q;
    logic       rf_w_en_d, rf_w_en_q;
    logic       dm_w_en_d, dm_w_en_q;
    logic       dm_r_en_d, dm_r_en_q;
    logic       is_jal_d, is_jal_q;

    always_comb begin
        // Everything defaults to the NOP bubble; only legal encodings below
        // override any field.
        addr_0_d  = 3'b0;
        addr_1_d  = 3'b0;
        w_addr_d  = 3'b0;
        imm_d     = 8'b0;
        alu_op_d  = 7'b0;
        branch_d  = 1'b0;
        mem2reg_d = 1'b0;
        alu_src_d = 1'b0;
        rf_w_en_d = 1'b0;
        dm_w_en_d = 1'b0;
        dm_r_en_d = 1'b0;
        is_jal_d  = 1'b0;

        case (op)
            OP_RTYPE: begin
                if (f2 == 2'b11) begin
                    // Shift-immediate: shamt lives in the rb field.
                    if (fn[1] == 1'b0) begin
                        w_addr_d  = rd;
                        addr_0_d  = ra;
                        imm_d     = {5'b0, rb};
                        alu_src_d = 1'b1;
                        rf_w_en_d = 1'b1;
                        alu_op_d  = {op, f2, fn};
                    end
                end else if ((f2 == 2'b10) ? (fn[1] == 1'b0) : (fn != 2'b11)) begin
                    // Register-register ALU.
                    w_addr_d  = rd;
                    addr_0_d  = ra;
                    addr_1_d  = rb;
                    rf_w_en_d = 1'b1;
                    alu_op_d  = {op, f2, fn};
                end
            end
            OP_ALUI: begin
                w_addr_d  = rd;
                addr_0_d  = ra;
                imm_d     = simm5;
                alu_src_d = 1'b1;
                rf_w_en_d = 1'b1;
                alu_op_d  = {op, f2, 2'b00};
            end
            OP_BRANCH: begin
                if (f2 != 2'b11) begin
                    // Branch compares the registers named by rd and ra.
                    addr_0_d = rd;
                    addr_1_d = ra;
                    imm_d    = simm5;
                    branch_d = 1'b1;
                    alu_op_d = {op, f2, 2'b00};
                end
            end
            OP_JAL: begin
                if (f2 == 2'b00) begin
                    w_addr_d  = rd;
                    imm_d     = bus.inst[7:0];
                    is_jal_d  = 1'b1;
                    rf_w_en_d = 1'b1;
                    alu_op_d  = {op, f2, 2'b00};
                end
            end
            OP_MEM: begin
                if (f2 == 2'b00) begin
                    // Load
                    w_addr_d  = rd;
                    addr_0_d  = ra;
                    imm_d     = simm5;
                    alu_src_d = 1'b1;
                    dm_r_en_d = 1'b1;
                    mem2reg_d = 1'b1;
                    rf_w_en_d = 1'b1;
                    alu_op_d  = {op, f2, 2'b00};
                end else if (f2 == 2'b01) begin
                    // Store: rd field carries the data register.
                    addr_0_d  = ra;
                    addr_1_d  = rd;
                    imm_d     = simm5;
                    alu_src_d = 1'b1;
                    dm_w_en_d = 1'b1;
                    alu_op_d  = {op, f2, 2'b00};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_0_q  <= 3'b0;
            addr_1_q  <= 3'b0;
            w_addr_q  <= 3'b0;
            imm_q     <= 8'b0;
            alu_op_q  <= 7'b0;
            branch_q  <= 1'b0;
            mem2reg_q <= 1'b0;
            alu_src_q <= 1'b0;
            rf_w_en_q <= 1'b0;
            dm_w_en_q <= 1'b0;
            dm_r_en_q <= 1'b0;
            is_jal_q  <= 1'b0;
        end else begin
            addr_0_q  <= addr_0_d;
            addr_1_q  <= addr_1_d;
            w_addr_q  <= w_addr_d;
            imm_q     <= imm_d;
            alu_op_q  <= alu_op_d;
            branch_q  <= branch_d;
            mem2reg_q <= mem2reg_d;
            alu_src_q <= alu_src_d;
            rf_w_en_q <= rf_w_en_d;
            dm_w_en_q <= dm_w_en_d;
            dm_r_en_q <= dm_r_en_d;
            is_jal_q  <= is_jal_d;
        end
    end

    assign bus.o_addr_0 = addr_0_q;
    assign bus.o_addr_1 = addr_1_q;
    assign bus.o_w_addr = w_addr_q;
    assign bus.imm      = imm_q;
    assign bus.ALU_OP   = alu_op_q;
    assign bus.Branch   = branch_q;
    assign bus.Mem2Reg  = mem2reg_q;
    assign bus.ALUSrc   = alu_src_q;
    assign bus.RF_w_en  = rf_w_en_q;
    assign bus.DM_w_en  = dm_w_en_q;
    assign bus.DM_r_en  = dm_r_en_q;
    assign bus.is_jal   = is_jal_q;

endmodule

// File: tb/tb_id_decoder.sv
module tb_id_decoder;

  localparam int W = 31;

  logic clk;
  logic rst_n;

  id_decoder_if bus ();

  id_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  // Observed outputs packed as
  // {addr0, addr1, waddr, imm, alu_op, Branch, Mem2Reg, ALUSrc, RF_w_en, DM_w_en, DM_r_en, is_jal}
  function automatic logic [W-1:0] observed();
    return {bus.o_addr_0, bus.o_addr_1, bus.o_w_addr, bus.imm, bus.ALU_OP,
            bus.Branch, bus.Mem2Reg, bus.ALUSrc, bus.RF_w_en, bus.DM_w_en,
            bus.DM_r_en, bus.is_jal};
  endfunction

  function automatic logic [W-1:0] pack(int a0, int a1, int wa, int im, int alu,
                                        bit br, bit m2r, bit src, bit rfw,
                                        bit dmw, bit dmr, bit jal);
    logic [2:0] a0v, a1v, wav;
    logic [7:0] imv;
    logic [6:0] aluv;
    a0v = a0[2:0]; a1v = a1[2:0]; wav = wa[2:0]; imv = im[7:0]; aluv = alu[6:0];
    return {a0v, a1v, wav, imv, aluv, br, m2r, src, rfw, dmw, dmr, jal};
  endfunction

  // Reference decode from the instruction-set rules, using integer fields.
  function automatic logic [W-1:0] ref_decode(logic [15:0] w);
    int op, f2, rd, ra, rb, fn, imm5, simm;
    op = int'(w) / 8192;
    f2 = (int'(w) / 2048) % 4;
    rd = (int'(w) / 256) % 8;
    ra = (int'(w) / 32) % 8;
    rb = (int'(w) / 4) % 8;
    fn = int'(w) % 4;
    imm5 = int'(w) % 32;
    simm = (imm5 >= 16) ? imm5 - 32 : imm5;
    simm = (simm + 256) % 256;
    if (op == 0 && f2 <= 1 && fn <= 2)
      return pack(ra, rb, rd, 0, f2 * 4 + fn, 0, 0, 0, 1, 0, 0, 0);
    if (op == 0 && f2 == 2 && fn <= 1)
      return pack(ra, rb, rd, 0, f2 * 4 + fn, 0, 0, 0, 1, 0, 0, 0);
    if (op == 0 && f2 == 3 && fn <= 1)
      return pack(ra, 0, rd, rb, f2 * 4 + fn, 0, 0, 1, 1, 0, 0, 0);
    if (op == 1)
      return pack(ra, 0, rd, simm, 16 + f2 * 4, 0, 0, 1, 1, 0, 0, 0);
    if (op == 2 && f2 <= 2)
      return pack(rd, ra, 0, simm, 32 + f2 * 4, 1, 0, 0, 0, 0, 0, 0);
    if (op == 3 && f2 == 0)
      return pack(0, 0, rd, int'(w) % 256, 48, 0, 0, 0, 1, 0, 0, 1);
    if (op == 4 && f2 == 0)
      return pack(ra, 0, rd, simm, 64, 0, 1, 1, 1, 0, 1, 0);
    if (op == 4 && f2 == 1)
      return pack(ra, rd, 0, simm, 68, 0, 0, 1, 0, 1, 0, 0);
    return '0;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: present a word at the falling edge, sample #1 after the rising edge
  task automatic drive_check(input logic [15:0] w, input string tag);
    @(negedge clk);
    bus.inst = w;
    @(posedge clk);
    #1;
    check(tag, observed(), ref_decode(w));
  endtask

  logic [15:0] directed[] = '{16'h0304, 16'h230A, 16'h2150, 16'h1B11, 16'h834A,
                              16'h8A6A, 16'h4206, 16'h630A};
  logic [15:0] illegal[] = '{16'hFFFF, 16'h0003, 16'h1002, 16'h1802, 16'h5800,
                             16'h6800, 16'h7000, 16'h7800, 16'h9000, 16'h9800,
                             16'hA000, 16'hC123, 16'hE456};

  initial begin
    logic [15:0] w;
    logic [W-1:0] o;
    bus.inst = 16'h0000;
    rst_n = 1'b1;

    // Load something non-zero, then assert reset mid-cycle.
    drive_check(16'h630A, "pre_reset_jal");
    @(negedge clk);
    bus.inst = 16'h0304;
    #2 rst_n = 1'b0;
    #1 check("async_reset", observed(), '0);
    @(posedge clk);
    #1 check("reset_held", observed(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("first_after_reset",
             observed(), pack(0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0));

    // Directed legal encodings with spec-quoted field values.
    drive_check(16'h230A, "addi");
    check("addi_const", observed(), pack(0, 0, 3, 8'h0A, 7'b0010000, 0, 0, 1, 1, 0, 0, 0));
    drive_check(16'h2150, "addi_neg");
    check("addi_neg_imm", {23'b0, bus.imm}, {23'b0, 8'hF0});
    drive_check(16'h1B11, "srli");
    check("srli_const", observed(), pack(0, 0, 3, 8'h04, 7'b0001101, 0, 0, 1, 1, 0, 0, 0));
    drive_check(16'h834A, "ld");
    check("ld_const", observed(), pack(2, 0, 3, 8'h0A, 7'b1000000, 0, 1, 1, 1, 0, 1, 0));
    drive_check(16'h8A6A, "sd");
    check("sd_const", observed(), pack(3, 2, 0, 8'h0A, 7'b1000100, 0, 0, 1, 0, 1, 0, 0));
    drive_check(16'h4206, "branch");
    check("branch_const", observed(), pack(2, 0, 0, 8'h06, 7'b0100000, 1, 0, 0, 0, 0, 0, 0));
    drive_check(16'h630A, "jal");
    check("jal_const", observed(), pack(0, 0, 3, 8'h0A, 7'b0110000, 0, 0, 0, 1, 0, 0, 1));

    // Illegal encodings, each preceded by a legal word so stale fields show.
    foreach (illegal[i]) begin
      drive_check(directed[i % 8], "legal_before_illegal");
      drive_check(illegal[i], "illegal");
      check("illegal_zero", observed(), '0);
    end

    // Mid-stream reset discards the current decode; queue is flushed too.
    drive_check(16'h834A, "pre_midreset");
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("midstream_reset", observed(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random regression: one word per cycle, scoreboard one cycle behind.
    exp_q.delete();
    for (int n = 0; n < 30000; n++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        o = observed();
        check("random", o, exp_q.pop_front());
        tests_run++;
        assert (!(o[5] && !(o[1] && o[3])) && !(o[2] && o[3]) && !(o[6] && o[0])) else begin
          tests_failed++;
          $error("FAIL strobe_consistency observed=%h expected=consistent", o);
        end
      end
      w = 16'($urandom_range(0, 65535));
      bus.inst = w;
      exp_q.push_back(ref_decode(w));
    end
    @(negedge clk);
    check("random_last", observed(), exp_q.pop_front());

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/id_decoder.md
# id_decoder

Instruction-decode stage of the 8-bit CPU. Takes the 16-bit instruction word from instruction memory and produces:
- register-file read/write addresses,
- an 8-bit immediate,
- a 7-bit ALU operation code,
- datapath control strobes.

Outputs are registered once, forming the IF/ID → EX boundary. Any illegal encoding decodes to an all-zero bubble (NOP).

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- inst  in  16  instruction word
- o_addr_0  out  3  register read address 0 (rs1 / base)
- o_addr_1  out  3  register read address 1 (rs2 / store data)
- o_w_addr  out  3  register write address (rd)
- imm  out  8  immediate
- ALU_OP  out  7  ALU operation code
- Branch, Mem2Reg, ALUSrc, RF_w_en, DM_w_en, DM_r_en, is_jal  out  1 each  control strobes

## Operation
- Fields: op = inst[15:13], f2 = inst[12:11], rd = inst[10:8], ra = inst[7:5], rb = inst[4:2], fn = inst[1:0].
- simm5 = imm5 sign-extended to 8 bits. Unused address outputs and imm are 0; unlisted strobes are 0.

**Legal encodings**
- op=000, R-type ALU:
  - Legal: f2=00 or 01 with fn ∈ {00,01,10}; f2=10 with fn ∈ {00,01}.
  - Outputs: o_w_addr=rd, o_addr_0=ra, o_addr_1=rb, imm=0, RF_w_en=1, ALUSrc=0.
- op=000, f2=11, shift-immediate:
  - Legal: fn=00 (slli), fn=01 (srli).
  - Outputs: o_w_addr=rd, o_addr_0=ra, o_addr_1=0, imm={5'b0, rb}, ALUSrc=1, RF_w_en=1.
- op=001, ALU immediate (all f2 legal):
  - Outputs: o_w_addr=rd, o_addr_0=ra, imm=simm5(inst[4:0]), ALUSrc=1, RF_w_en=1.
- op=010, branch (f2 ∈ {00,01,10}):
  - Outputs: o_addr_0=rd field (inst[10:8]), o_addr_1=ra field (inst[7:5]), imm=simm5(inst[4:0]), Branch=1, ALUSrc=0, o_w_addr=0.
- op=011, f2=00, JAL:
  - Outputs: o_w_addr=rd, imm=inst[7:0], is_jal=1, RF_w_en=1.
- op=100, f2=00, LD:
  - Outputs: o_w_addr=rd, o_addr_0=ra, imm=simm5(inst[4:0]), ALUSrc=1, DM_r_en=1, Mem2Reg=1, RF_w_en=1.
- op=100, f2=01, SD:
  - Outputs: o_addr_0=ra (base), o_addr_1=inst[10:8] (data), imm=simm5(inst[4:0]), ALUSrc=1, DM_w_en=1, o_w_addr=0.

**ALU_OP encoding**
- R-type and shift-immediate: ALU_OP = {op, f2, fn}.
- All other legal encodings: ALU_OP = {op, f2, 2'b00}.

**Illegal encodings** (every code not listed above, including op 101–111, e.g. 16'hFFFF)
- Every output, including ALU_OP, is 0.

## Timing
- Decode logic is combinational; all outputs are registered on the rising edge of clk.
- Latency is 1 cycle: the values decoded from inst at edge N appear after edge N and hold until edge N+1.
- rst_n low clears every output to 0 immediately, independent of clk; the cleared state equals an illegal/NOP decode.
- While rst_n is low, outputs stay 0 regardless of inst.
- After rst_n deasserts, outputs reflect inst from the first following rising edge.
- Reset asserted mid-stream discards the in-flight decode; nothing is replayed.
- No handshake: a new instruction is accepted every cycle.
- Control strobes are mutually consistent by construction: Mem2Reg implies DM_r_en and RF_w_en; DM_w_en implies RF_w_en=0; Branch and is_jal are never both 1.

## Test plan
- Reset: rst_n=0 asynchronously, mid-cycle, with inst=0x0304 → all outputs 0 at once. Release rst_n, apply 0x0304 (add: rd=3, ra=0, rb=1), clock → o_w_addr=3, o_addr_0=0, o_addr_1=1, ALU_OP=0000000, RF_w_en=1, all other strobes 0.
- ALU immediate / shift-immediate:
  - 0x230A (addi rd=3, ra=0, imm=01010) → imm=0x0A, ALUSrc=1, RF_w_en=1, ALU_OP=0010000.
  - 0x2150 (ra=2, imm=10000) → imm=0xF0.
  - 0x1B11 (srli rd=3, ra=0, shamt=4) → imm=0x04, o_addr_1=0, ALUSrc=1, ALU_OP=0001101.
- Memory:
  - 0x834A (LD) → o_w_addr=3, o_addr_0=2, imm=0x0A, DM_r_en=1, Mem2Reg=1, RF_w_en=1, ALUSrc=1.
  - 0x8A6A (SD) → o_addr_0=3, o_addr_1=2, imm=0x0A, DM_w_en=1, RF_w_en=0.
- Control flow:
  - 0x4206 (branch) → o_addr_0=2, o_addr_1=0, imm=0x06, Branch=1, o_w_addr=0.
  - 0x630A (JAL) → o_w_addr=3, imm=0x0A, is_jal=1, RF_w_en=1.
- Illegal codes: 0xFFFF, op=000 with (f2=00, fn=11) / (f2=10, fn=10) / (f2=11, fn=10), op=010 f2=11, op=011 f2≠00, op=100 f2 ∈ {10,11} → all outputs 0 after the clock edge.
- Random regression: 30000 random words, one per cycle, compared against a reference decode model one cycle later; confirm back-to-back instructions never leak fields from the prior cycle.
